// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage with a DEPTH-entry prefetch FIFO.
//                Owns the fetch PC and issues sequential word requests to a
//                one-cycle-latency instruction memory. Returned words are
//                buffered with their PCs and presented to decode over a
//                valid/ready handshake. A redirect flushes the buffer, drops
//                any in-flight response and restarts fetch at the target.
//  Options     : FETCH_BYPASS_EN - when defined, a response arriving while
//                the FIFO is empty is forwarded straight to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [WIDTH-1:0]           instr,
  output logic [WIDTH-1:0]           instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Architectural state
  logic [WIDTH-1:0] r_fetch_pc;
  logic             r_inflight;
  logic [WIDTH-1:0] r_req_pc;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_pc_mem  [DEPTH];
  logic [WIDTH-1:0] r_ins_mem [DEPTH];

  // Control wires
  logic [WIDTH-1:0] w_target;
  logic [CW:0]      w_occ;
  logic             w_req;
  logic             w_resp;
  logic             w_byp;
  logic             w_valid;
  logic             w_pop;
  logic             w_fifo_pop;
  logic             w_push;

  // Request credit, response acceptance, bypass and handshake decode
  always_comb begin
    // Masking keeps every redirect_pc bit live while forcing word alignment.
    w_target = redirect_pc & ~WIDTH'(3);
    // Credit counts outstanding work without assuming a same-cycle pop, so a
    // granted request always finds room when its response lands.
    w_occ    = {1'b0, r_count} + (CW+1)'(r_inflight);
    w_req    = !rst && !redirect && (w_occ < (CW+1)'(DEPTH));
    w_resp   = r_inflight && !redirect && !rst;
`ifdef FETCH_BYPASS_EN
    w_byp    = w_resp && (r_count == '0);
`else
    w_byp    = 1'b0;
`endif
    w_valid    = (r_count != '0) || w_byp;
    w_pop      = w_valid && instr_ready;
    w_fifo_pop = w_pop && (r_count != '0);
    // A bypassed response that decode takes immediately never enters the FIFO.
    w_push     = w_resp && !(w_byp && instr_ready);
  end

  // Output drive: FIFO head, or the live response when bypassing an empty FIFO
  always_comb begin
    imem_req    = w_req;
    imem_addr   = r_fetch_pc;
    instr_valid = w_valid;
    count       = r_count;
    instr       = r_ins_mem[r_rd_ptr];
    instr_pc    = r_pc_mem[r_rd_ptr];
    if (w_byp) begin
      instr    = imem_rdata;
      instr_pc = r_req_pc;
    end
  end

  // Fetch PC, in-flight tracking and FIFO pointer/occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_req_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      // Flush everything; a response due now or next cycle is simply dropped.
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_req) begin
        r_fetch_pc <= r_fetch_pc + WIDTH'(4);
        r_req_pc   <= r_fetch_pc;
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy qualifies them
  always_ff @(posedge clk) begin
    if (w_push && !rst && !redirect) begin
      r_pc_mem[r_wr_ptr]  <= r_req_pc;
      r_ins_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A one-cycle memory model
//                answers requests; a scoreboard queue holds the PCs decode is
//                owed and is compared on every accepted instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          WIDTH    = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  // Scoreboard / reference model state
  logic [31:0] r_q [$];
  logic [31:0] r_exp_addr = RESET_PC;
  logic        r_pend     = 1'b0;
  logic [31:0] r_pend_addr = 32'h0;
  logic        r_exp_req;
  logic        r_exp_valid;
  logic [31:0] r_head;

  fetch_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory: data valid one cycle after the request
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  end

  // Reference model evaluated mid-cycle, ahead of the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      check("req_in_rst", {31'b0, imem_req}, 32'h0);
      r_q.delete();
      r_pend     = 1'b0;
      r_exp_addr = RESET_PC;
    end else begin
      r_exp_req   = !redirect && ((r_q.size() + int'(r_pend)) < DEPTH);
`ifdef FETCH_BYPASS_EN
      r_exp_valid = (r_q.size() != 0) || (r_pend && !redirect);
`else
      r_exp_valid = (r_q.size() != 0);
`endif
      check("count", {29'b0, count}, 32'(r_q.size()));
      check("instr_valid", {31'b0, instr_valid}, {31'b0, r_exp_valid});
      check("imem_req", {31'b0, imem_req}, {31'b0, r_exp_req});
      if (r_pend && !redirect) begin
        r_q.push_back(r_pend_addr);
      end
      if (instr_valid && instr_ready) begin
        if (r_q.size() == 0) begin
          check("pop_nonempty", 32'(r_q.size()), 32'h1);
        end else begin
          r_head = r_q.pop_front();
          check("instr_pc", instr_pc, r_head);
          check("instr", instr, mem_word(r_head));
        end
      end
      if (redirect) begin
        r_q.delete();
        r_pend     = 1'b0;
        r_exp_addr = redirect_pc & ~32'h3;
      end else if (imem_req) begin
        check("imem_addr", imem_addr, r_exp_addr);
        r_pend      = 1'b1;
        r_pend_addr = r_exp_addr;
        r_exp_addr  = r_exp_addr + 32'h4;
      end else begin
        r_pend = 1'b0;
      end
    end
  end

  task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc, input logic r);
    @(posedge clk);
    #1;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    rst         = r;
  endtask

  initial begin
    // Reset, then free-running fetch with decode always ready
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Decode stalls: FIFO fills and requests stop
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("sat_count", {29'b0, count}, 32'(DEPTH));
    check("sat_req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect to an unaligned target with a partly full FIFO
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("flush_count", {29'b0, count}, 32'h0);
    check("flush_valid", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect coinciding with a pop and a response, then back-to-back redirects
    drive(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check("pop_redir_count", {29'b0, count}, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0300, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0404, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Fetch PC wraps past the top of the address space
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Reset in mid-stream with entries buffered
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check("rst_count", {29'b0, count}, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Randomised traffic: stalls, redirects and occasional resets
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0,
            $urandom,
            $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage with a prefetch buffer, the successor to the single-cycle PC-register-plus-instruction-memory path. It owns the fetch PC, issues sequential word requests to a fixed-latency instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Each buffered instruction is presented to decode over a valid/ready handshake. A redirect from branch/jump resolution flushes the buffer, discards any in-flight response, and restarts fetch at the target.

## Interface
- WIDTH, 32, PC and instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0, fetch PC loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  WIDTH  request address; word-aligned.
- imem_rdata  in  WIDTH  instruction data, valid exactly 1 cycle after an accepted request.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  WIDTH  restart address; bits [1:0] forced to 0.
- instr_valid  out  1  instr/instr_pc hold a valid entry.
- instr_ready  in  1  decode accepts the entry this cycle.
- instr  out  WIDTH  instruction.
- instr_pc  out  WIDTH  PC of instr.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- State:
  - fetch_pc;
  - inflight flag (request issued last cycle, response pending);
  - FIFO of {pc, instr} with read/write pointers, wrap modulo DEPTH, and occupancy count.
- Request rule: imem_req = !rst && !redirect && (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On request: fetch_pc += 4, with modulo 2^WIDTH wrap; inflight <= 1 and the request PC is recorded. Otherwise inflight <= 0.
  - Credit uses the current count, without crediting a same-cycle pop, so the FIFO never overflows and no response is ever dropped for lack of space.
- Response: when inflight and no redirect, {recorded pc, imem_rdata} is written to the FIFO.
- Output: head entry drives instr/instr_pc. instr_valid = (count != 0). A pop occurs when instr_valid && instr_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. At count==DEPTH no push can occur (credit rule).
- Redirect, highest priority:
  - Same edge: FIFO pointers and count cleared, inflight cleared (the response in this cycle or the next is discarded), fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - No request in the redirect cycle.
  - A pop coinciding with redirect is considered consumed by decode; flush proceeds regardless.
  - Back-to-back redirects: the last one wins.
- Throughput: one instruction per cycle sustained when instr_ready is held high.

## Timing
- Reset values: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, instr_valid=0, imem_req=0 while rst is high. instr/instr_pc are don't-care while instr_valid=0.
- Reset mid-operation overrides redirect and all in-flight state; a response arriving the cycle after reset is discarded.
- Cycle 0 = first cycle with rst low: imem_req=1, imem_addr=RESET_PC. Cycle 1: response written. Cycle 2: instr_valid=1, instr_pc=RESET_PC.
- Redirect asserted at cycle R: request to target at R+1; instr_valid for target at R+3 (R+2 with bypass).
- Outputs are registered from FIFO state except under bypass (see Configuration).

## Configuration
- FETCH_BYPASS_EN defined: when count==0 and a response is valid (inflight && !redirect), instr/instr_pc/instr_valid are driven combinationally from imem_rdata and the recorded PC.
  - If instr_ready=1, the entry is consumed and not written.
  - Otherwise it is written normally.
  - Fetch-to-decode latency drops by 1 cycle.
- Undefined: every response passes through the FIFO; instr_valid depends only on count.

## Test plan
- Reset release, instr_ready=1, memory returns addr as data -> instr_pc/instr = 0,4,8,… one per cycle from cycle 2. Cycle 1 with FETCH_BYPASS_EN.
- instr_ready=0 for 10 cycles -> count saturates at 4, imem_req stays 0 once count+inflight=4, no data lost. On release, PCs 0,4,8,12,16 are delivered in order.
- redirect with redirect_pc=32'h103 while count=3 and inflight=1 -> next cycle count=0, instr_valid=0. Next request addr=32'h100. Stale response not delivered. First delivered instr_pc=32'h100.
- redirect coinciding with a pop and a response -> pop counts, response discarded, count=0 next cycle.
- fetch_pc=32'hFFFF_FFFC, WIDTH=32 -> next request addr=0 (wrap).
- rst asserted mid-stream with count=2 -> next cycle count=0, instr_valid=0. First request after release addr=RESET_PC.
